// File: rtl/mem_ctrl.sv
// Single-port byte-wide RAM controller arbitrating between instruction fetch and the MEM stage.
// Serializes 1/2/4-byte accesses into byte transfers and assembles little-endian load data.
module mem_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_done,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic [2:0]  mem_length,
  input  logic        mem_signed,
  output logic [31:0] mem_read_data,
  output logic        mem_done,
  output logic        stall_req_if,
  output logic        stall_req_mem,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic [1:0]  fsm_state
);

  // Handshake: a requester holds its request (and operands) high until it sees its
  // one-cycle done pulse; the controller ignores requests during DONE, so the
  // requester may present the next request from the cycle after done.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [2:0]  len;
  logic [2:0]  cnt;
  logic [2:0]  cap;
  logic        owner_mem;
  logic        sgn;
  logic        rd_active;
  logic        cap_pending;
  logic [2:0]  req_len;
  logic [31:0] word_next;
  logic [31:0] load_ext;

  assign stall_req_if  = if_req & ~if_done;
  assign stall_req_mem = (mem_load | mem_store) & ~mem_done;
  assign fsm_state     = state;

  always_comb begin
    case (mem_length)
      3'd1:    req_len = 3'd1;
      3'd2:    req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
  end

  // Word with the byte arriving this cycle merged in, plus its load extension.
  always_comb begin
    word_next = rbuf;
    word_next[{cap[1:0], 3'b000} +: 8] = ram_din;
    case (len)
      3'd1:    load_ext = {{24{sgn & word_next[7]}}, word_next[7:0]};
      3'd2:    load_ext = {{16{sgn & word_next[15]}}, word_next[15:0]};
      default: load_ext = word_next;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      base          <= 32'd0;
      wdata         <= 32'd0;
      rbuf          <= 32'd0;
      len           <= 3'd0;
      cnt           <= 3'd0;
      cap           <= 3'd0;
      owner_mem     <= 1'b0;
      sgn           <= 1'b0;
      rd_active     <= 1'b0;
      cap_pending   <= 1'b0;
      ram_addr      <= 32'd0;
      ram_wr        <= 1'b0;
      ram_dout      <= 8'd0;
      if_done       <= 1'b0;
      mem_done      <= 1'b0;
      if_inst       <= 32'd0;
      mem_read_data <= 32'd0;
    end else begin
      ram_wr   <= 1'b0;
      ram_addr <= 32'd0;
      ram_dout <= 8'd0;
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt         <= 3'd1;
          cap         <= 3'd0;
          cap_pending <= 1'b0;
          rd_active   <= 1'b0;
          rbuf        <= 32'd0;
          if (mem_store) begin
            base      <= mem_addr;
            wdata     <= mem_write_data;
            len       <= req_len;
            owner_mem <= 1'b1;
            ram_wr    <= 1'b1;
            ram_addr  <= mem_addr;
            ram_dout  <= mem_write_data[7:0];
            state     <= WRITE;
          end else if (mem_load) begin
            base      <= mem_addr;
            len       <= req_len;
            sgn       <= mem_signed;
            owner_mem <= 1'b1;
            ram_addr  <= mem_addr;
            rd_active <= 1'b1;
            state     <= READ;
          end else if (if_req) begin
            base      <= if_addr;
            len       <= 3'd4;
            sgn       <= 1'b0;
            owner_mem <= 1'b0;
            ram_addr  <= if_addr;
            rd_active <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          // ram_din lags the address by one cycle, so captures trail issues by one.
          cap_pending <= rd_active;
          if (cnt < len) begin
            ram_addr  <= base + {29'd0, cnt};
            cnt       <= cnt + 3'd1;
            rd_active <= 1'b1;
          end else begin
            rd_active <= 1'b0;
          end
          if (cap_pending) begin
            rbuf <= word_next;
            cap  <= cap + 3'd1;
            if (cap == len - 3'd1) begin
              if (owner_mem) begin
                mem_done      <= 1'b1;
                mem_read_data <= load_ext;
              end else begin
                if_done <= 1'b1;
                if_inst <= word_next;
              end
              state <= DONE;
            end
          end
        end
        WRITE: begin
          if (cnt < len) begin
            ram_wr   <= 1'b1;
            ram_addr <= base + {29'd0, cnt};
            ram_dout <= wdata[{cnt[1:0], 3'b000} +: 8];
            cnt      <= cnt + 3'd1;
          end else begin
            mem_done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and arbiter that shares the 8-bit external RAM between instruction fetch (IF) and the MEM stage (loads/stores). It serializes 1/2/4-byte accesses into byte transfers, assembles little-endian read data, and raises per-stage stall requests that feed the pipeline stall bus. MEM has priority over IF; a started transaction always runs to completion.

## Interface
Parameters: none.

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  32  fetch byte address (always 4-byte read)
- if_inst  out  32  fetched word, valid while if_done=1
- if_done  out  1  one-cycle completion pulse for fetch
- mem_load  in  1  load request from MEM stage
- mem_store  in  1  store request from MEM stage
- mem_addr  in  32  data byte address
- mem_write_data  in  32  store data, bytes taken LSB first
- mem_length  in  3  access bytes: 1, 2, 4; other values are treated as 4
- mem_signed  in  1  1 = sign-extend load, 0 = zero-extend
- mem_read_data  out  32  extended load result, valid while mem_done=1
- mem_done  out  1  one-cycle completion pulse for load/store
- stall_req_if  out  1  = if_req & ~if_done (combinational)
- stall_req_mem  out  1  = (mem_load | mem_store) & ~mem_done (combinational)
- ram_addr  out  32  RAM byte address
- ram_wr  out  1  1 = write ram_dout at ram_addr this cycle
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid one cycle after its address is driven

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If mem_store=1: latch address, data and length N; go to WRITE.
  - Else if mem_load=1: latch request; go to READ.
  - Else if if_req=1: latch if_addr with N=4; go to READ.
  - Priority is store > load > fetch. mem_load and mem_store both high is illegal, and store wins.
- READ, counter i from 0:
  - Each cycle with i<N, drive ram_addr = base+i, ram_wr=0, then i++.
  - Byte returned for address base+k is captured into byte k one cycle later.
  - After the last byte is captured, go to DONE.
- WRITE, counter i:
  - Each cycle drive ram_wr=1, ram_addr=base+i, ram_dout=byte i of data, then i++.
  - After byte N-1, go to DONE.
- DONE:
  - Assert the owner's done pulse with registered data for exactly one cycle.
  - Requests are ignored in this cycle.
  - Go to IDLE. The requester advances on the done edge, so the next IDLE cycle sees the new request.
- Load result:
  - N=1: byte0, extended from bit 7.
  - N=2: {byte1, byte0}, extended from bit 15.
  - N=4: the raw word.
  - Fetch results are never extended.
- Address arithmetic: base+i wraps modulo 2^32.
- When not issuing (IDLE, DONE, the final capture cycle of READ): ram_wr=0, ram_addr=0, ram_dout=0.

## Timing
Cycle 0 is the IDLE cycle in which the request is sampled.

- Load or fetch of N bytes: addresses in cycles 1..N; captures at the ends of cycles 2..N+1; done high in cycle N+2.
  - Fetch: done in cycle 6.
  - Byte load: done in cycle 3.
- Store of N bytes: writes in cycles 1..N; done high in cycle N+1.
- Back-to-back requests: the earliest next acceptance is cycle N+3 (load) or N+2 (store). There is one IDLE cycle after DONE.
- A fetch arriving while MEM is in flight waits. If both are pending in IDLE, MEM is served first and the fetch starts in the IDLE cycle after MEM's DONE.
- Reset values (effective the cycle after reset is sampled, including mid-transaction):
  - state IDLE, counters 0.
  - ram_wr=0, ram_addr=0, ram_dout=0.
  - if_done=0, mem_done=0, if_inst=0, mem_read_data=0.
- A partially written store is not rolled back.

## Test plan
- Fetch only: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,00,00,00 -> ram_addr 0x100..0x103 in cycles 1-4; if_done in cycle 6 with if_inst=0x00000013; stall_req_if=1 in cycles 0-5.
- Signed byte load: mem_load=1, mem_length=1, mem_signed=1, RAM[0x20]=0x80 -> mem_done in cycle 3, mem_read_data=0xFFFFFF80. With mem_signed=0 -> 0x00000080.
- Halfword store: mem_store=1, mem_length=2, addr=0x40, data=0xAABBCCDD -> ram_wr=1 with (0x40,DD) in cycle 1 and (0x41,CC) in cycle 2; mem_done in cycle 3; RAM[0x42] untouched.
- Conflict: if_req and mem_load (N=4) raised together -> MEM served first (mem_done in cycle 6); IDLE in cycle 7; fetch addresses start in cycle 8; if_done in cycle 13; stall_req_if held high throughout.
- Wrap: word load at 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, assembled little-endian.
- Reset mid-store: assert reset in cycle 2 of a 4-byte store -> ram_wr=0 from cycle 3; no done pulse; state IDLE; all outputs at reset values.
